// File: rtl/uart_ring_buffer_pkg.sv
// uart_ring_buffer_pkg
// Shared defaults, types and debug-word field positions for the UART ring
// buffer. The typedefs are sized for the default geometry; modules that take
// DEPTH/DATA_W as parameters derive their own widths from those parameters.
package uart_ring_buffer_pkg;

  localparam int DEFAULT_DEPTH  = 4;
  localparam int DEFAULT_DATA_W = 8;

  typedef logic [DEFAULT_DATA_W-1:0]        byte_t;
  typedef logic [$clog2(DEFAULT_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEFAULT_DEPTH):0]   cnt_t;

  // debug : [31:16] write pointer, [15:0] read pointer
  // debug2: [31:16] dropped-write count, [15:0] occupancy
  localparam int DBG_FIELD_W  = 16;
  localparam int DBG_WP_LSB   = 16;
  localparam int DBG_RP_LSB   = 0;
  localparam int DBG_DROP_LSB = 16;
  localparam int DBG_CNT_LSB  = 0;

endpackage

// File: rtl/uart_rb_mem.sv
// uart_rb_mem
// DEPTH x DATA_W storage with a synchronous write port and a registered read
// port. The storage array is not reset; only the read-data register is.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset (clears rd_data only)
//   wr_en    write strobe, wr_addr/wr_data captured on the edge
//   rd_en    read strobe, rd_data <= mem[rd_addr] on the edge, else holds
//   rd_data  registered read data
module uart_rb_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_ring_buffer.sv
// uart_ring_buffer
// Byte-wide circular FIFO between a UART path and its consumer. Writes while
// full are dropped; reads return a registered byte with a one-cycle ack.
// Optional feature macro: UART_RING_BUFFER_DEBUG_EN enables the drop counter
// and drives debug/debug2; without it both debug words read 32'h0.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   writeEnable  push request;  data = byte to push
//   readEnable   pop request
//   dataReadAck  1 for the cycle after a successful pop
//   dataRead     popped byte (holds between pops)
//   debug        {write pointer, read pointer}, each zero-extended to 16 bits
//   debug2       {dropped-write count, occupancy}, each 16 bits
module uart_ring_buffer
  import uart_ring_buffer_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEnable,
  input  logic [DATA_W-1:0] data,
  input  logic              readEnable,
  output logic              dataReadAck,
  output logic [DATA_W-1:0] dataRead,
  output logic [31:0]       debug,
  output logic [31:0]       debug2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  // Flags come from the pre-edge count, so a same-cycle read never frees
  // space for a write and a same-cycle write never feeds a read.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = writeEnable && !full;
  assign rd_ok = readEnable && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      dataReadAck <= 1'b0;
    end else begin
      dataReadAck <= rd_ok;
      if (wr_ok) wp <= wp + PTR_W'(1);
      if (rd_ok) rp <= rp + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  uart_rb_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wp),
    .wr_data (data),
    .rd_en   (rd_ok),
    .rd_addr (rp),
    .rd_data (dataRead)
  );

`ifdef UART_RING_BUFFER_DEBUG_EN
  logic [DBG_FIELD_W-1:0] drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_cnt <= '0;
    else if (writeEnable && full && (drop_cnt != {DBG_FIELD_W{1'b1}}))
      drop_cnt <= drop_cnt + DBG_FIELD_W'(1);
  end

  assign debug  = (32'(wp) << DBG_WP_LSB) | (32'(rp) << DBG_RP_LSB);
  assign debug2 = (32'(drop_cnt) << DBG_DROP_LSB) | (32'(count) << DBG_CNT_LSB);
`else
  assign debug  = 32'h0;
  assign debug2 = 32'h0;
`endif

endmodule

// File: tb/tb_uart_ring_buffer.sv
module tb_uart_ring_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       writeEnable;
  logic [7:0] data;
  logic       readEnable;
  logic       dataReadAck;
  logic [7:0] dataRead;
  logic [31:0] debug;
  logic [31:0] debug2;

  uart_ring_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .data        (data),
    .readEnable  (readEnable),
    .dataReadAck (dataReadAck),
    .dataRead    (dataRead),
    .debug       (debug),
    .debug2      (debug2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stored bytes plus running totals.
  logic [7:0] q[$];
  int         wr_total;
  int         rd_total;
  int         drops;
  logic       m_ack;
  logic [7:0] m_data;

  int checks;
  int passes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_debug();
`ifdef UART_RING_BUFFER_DEBUG_EN
    return {16'(wr_total % DEPTH), 16'(rd_total % DEPTH)};
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_debug2();
`ifdef UART_RING_BUFFER_DEBUG_EN
    return {16'(drops), 16'(q.size())};
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ack"},    32'(dataReadAck), 32'(m_ack));
    chk({tag, ".data"},   32'(dataRead),    32'(m_data));
    chk({tag, ".debug"},  debug,            exp_debug());
    chk({tag, ".debug2"}, debug2,           exp_debug2());
  endtask

  task automatic cyc(input string tag, input logic we, input logic [7:0] d, input logic re);
    bit full;
    bit empty;
    bit rd_ok;
    bit wr_ok;
    writeEnable = we;
    data        = d;
    readEnable  = re;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    rd_ok = re && !empty;
    wr_ok = we && !full;
    @(posedge clk);
    #1;
    m_ack = rd_ok;
    if (rd_ok) begin
      m_data = q.pop_front();
      rd_total++;
    end
    if (wr_ok) begin
      q.push_back(d);
      wr_total++;
    end else if (we && drops < 65535) begin
      drops++;
    end
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    wr_total = 0;
    rd_total = 0;
    drops    = 0;
    m_ack    = 1'b0;
    m_data   = 8'h00;
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic async_reset(input string tag);
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    model_reset();
    reset       = 1'b0;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    data        = 8'h00;

    // Reset state
    #12;
    chk("reset.ack",    32'(dataReadAck), 32'h0);
    chk("reset.data",   32'(dataRead),    32'h0);
    chk("reset.debug",  debug,            32'h0);
    chk("reset.debug2", debug2,           32'h0);
    reset = 1'b1;

    // Fill then partial drain
    cyc("push1", 1'b1, 8'h01, 1'b0);
    cyc("push2", 1'b1, 8'h02, 1'b0);
    cyc("push3", 1'b1, 8'h03, 1'b0);
    cyc("pop1",  1'b0, 8'h00, 1'b1);
    chk("pop1.val", 32'(dataRead), 32'h01);
    cyc("pop2",  1'b0, 8'h00, 1'b1);
    chk("pop2.val", 32'(dataRead), 32'h02);
    cyc("idle",  1'b0, 8'h00, 1'b0);
    chk("idle.ack", 32'(dataReadAck), 32'h0);

    // Wrap, full, drop, drain past empty
    cyc("push6", 1'b1, 8'h06, 1'b0);
    cyc("push7", 1'b1, 8'h07, 1'b0);
    cyc("push8", 1'b1, 8'h08, 1'b0);
    cyc("push9_drop", 1'b1, 8'h09, 1'b0);
    for (int i = 0; i < 5; i++) cyc($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1);
    chk("drain4.ack",  32'(dataReadAck), 32'h0);
    chk("drain4.hold", 32'(dataRead),    32'h08);

    // Empty read
    cyc("empty_rd", 1'b0, 8'h00, 1'b1);

    // Simultaneous read/write when full and when empty
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 8'h20 + 8'(i), 1'b0);
    cyc("both_full", 1'b1, 8'h5A, 1'b1);
    chk("both_full.val", 32'(dataRead), 32'h20);
    for (int i = 0; i < DEPTH - 1; i++) cyc("drain_b", 1'b0, 8'h00, 1'b1);
    cyc("both_empty", 1'b1, 8'hA5, 1'b1);
    chk("both_empty.ack", 32'(dataReadAck), 32'h0);
    cyc("pop_a5", 1'b0, 8'h00, 1'b1);
    chk("pop_a5.val", 32'(dataRead), 32'hA5);

    // Mid-operation asynchronous reset
    cyc("pre_rst1", 1'b1, 8'h11, 1'b0);
    cyc("pre_rst2", 1'b1, 8'h12, 1'b0);
    async_reset("midrst");
    cyc("post_push", 1'b1, 8'h0A, 1'b0);
    cyc("post_pop",  1'b0, 8'h00, 1'b1);
    chk("post_pop.val", 32'(dataRead), 32'h0A);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      if (i == 150) async_reset("rand_rst");
      cyc("rand", ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
